// File: rtl/tdc_pkg.sv
// Shared definitions for the TDC start/stop stimulus path and the coarse counter.
package tdc_pkg;

  localparam int unsigned CNT_W        = 16;
  localparam int unsigned MAX_INTERVAL = 60000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START_HI,
    ST_BOTH_HI,
    ST_GAP,
    ST_DONE
  } state_e;

endpackage

// File: rtl/tdc_pulse_gen.sv
// Programmable start/stop level pair for TDC coarse-count self-test: start, stop N cycles later,
// both held PULSE_W cycles, both low GAP_CYC cycles, then a one-cycle done.
module tdc_pulse_gen #(
  parameter int unsigned CNT_W        = tdc_pkg::CNT_W,
  parameter int unsigned MAX_INTERVAL = tdc_pkg::MAX_INTERVAL,
  parameter int unsigned PULSE_W      = 4,
  parameter int unsigned GAP_CYC      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic [CNT_W-1:0] interval,
  input  logic             abort,
  output logic             start,
  output logic             stop,
  output logic             busy,
  output logic             done,
  output logic             clamped
);
  import tdc_pkg::*;

  localparam logic [CNT_W-1:0] L_MAX      = CNT_W'(MAX_INTERVAL);
  localparam logic [CNT_W-1:0] L_PULSE_LD = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] L_GAP_LD   = CNT_W'(GAP_CYC - 1);

  state_e           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0] w_n;
  logic             r_clamped, w_clamped_nxt;
  logic             r_start, r_stop, r_busy, r_done;

  assign w_n = (interval > L_MAX) ? L_MAX : interval;

  // One down-counter serves every timed phase; it is reloaded on each state entry.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_clamped_nxt = r_clamped;
    unique case (r_state)
      ST_IDLE: begin
        if (req) begin
          w_clamped_nxt = (interval > L_MAX);
          if (w_n == '0) begin
            w_state_nxt = ST_BOTH_HI;
            w_cnt_nxt   = L_PULSE_LD;
          end else begin
            w_state_nxt = ST_START_HI;
            w_cnt_nxt   = w_n - 1'b1;
          end
        end
      end
      ST_START_HI: begin
        if (abort) begin
          w_state_nxt = ST_GAP;
          w_cnt_nxt   = L_GAP_LD;
        end else if (r_cnt == '0) begin
          w_state_nxt = ST_BOTH_HI;
          w_cnt_nxt   = L_PULSE_LD;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      ST_BOTH_HI: begin
        if (abort || r_cnt == '0) begin
          w_state_nxt = ST_GAP;
          w_cnt_nxt   = L_GAP_LD;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      ST_GAP: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_DONE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so each level changes on the same edge as the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_clamped <= 1'b0;
      r_start   <= 1'b0;
      r_stop    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_clamped <= w_clamped_nxt;
      r_start   <= (w_state_nxt == ST_START_HI) || (w_state_nxt == ST_BOTH_HI);
      r_stop    <= (w_state_nxt == ST_BOTH_HI);
      r_busy    <= (w_state_nxt == ST_START_HI) || (w_state_nxt == ST_BOTH_HI) ||
                   (w_state_nxt == ST_GAP);
      r_done    <= (w_state_nxt == ST_DONE);
    end
  end

  assign start   = r_start;
  assign stop    = r_stop;
  assign busy    = r_busy;
  assign done    = r_done;
  assign clamped = r_clamped;

endmodule

// File: tb/tb_tdc_pulse_gen.sv
// Directed bench for tdc_pulse_gen: per-scenario cycle-exact waveform checks plus reset corners.
module tb_tdc_pulse_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic [15:0] interval;
  logic        abort;
  logic        start, stop, busy, done, clamped;

  int checks   = 0;
  int failures = 0;

  tdc_pulse_gen #(
    .CNT_W       (16),
    .MAX_INTERVAL(60000),
    .PULSE_W     (4),
    .GAP_CYC     (8)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .interval(interval),
    .abort   (abort),
    .start   (start),
    .stop    (stop),
    .busy    (busy),
    .done    (done),
    .clamped (clamped)
  );

  always #5 clk = ~clk;

  // Accept at cycle 0; start high [s_rise,fall), stop high [p_rise,fall), busy [1,done_c).
  typedef struct {
    string       name;
    logic [15:0] iv;
    int          abort_at;
    int          ign0;
    int          ign1;
    int          s_rise;
    int          p_rise;
    int          fall;
    int          done_c;
    logic        clmp;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int cyc, input logic [4:0] got, input logic [4:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      if (failures <= 30)
        $display("FAIL %s cyc=%0d start/stop/busy/done/clamped got=%b expected=%b", name, cyc, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    logic [4:0] exp;
    req      = 1'b1;
    interval = v.iv;
    abort    = (v.abort_at == 0);
    tick();
    for (int c = 1; c <= v.done_c + 2; c++) begin
      exp[4] = (c >= v.s_rise) && (c < v.fall);
      exp[3] = (c >= v.p_rise) && (c < v.fall);
      exp[2] = (c >= 1) && (c < v.done_c);
      exp[1] = (c == v.done_c);
      exp[0] = v.clmp;
      chk(v.name, c, {start, stop, busy, done, clamped}, exp);
      req      = (c == v.ign0) || (c == v.ign1);
      interval = 16'd7;
      abort    = (c == v.abort_at);
      tick();
    end
    req   = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    vecs.push_back('{"nominal5",   16'd5,     -1, -1, -1, 1, 6,     10,    18,    1'b0});
    vecs.push_back('{"zero",       16'd0,     -1, -1, -1, 1, 1,     5,     13,    1'b0});
    vecs.push_back('{"one",        16'd1,     -1, -1, -1, 1, 2,     6,     14,    1'b0});
    vecs.push_back('{"abort_start",16'd100,   20, 10, 29, 1, 10000, 21,    29,    1'b0});
    vecs.push_back('{"abort_both", 16'd3,     5,  -1, -1, 1, 4,     6,     14,    1'b0});
    vecs.push_back('{"abort_gap",  16'd2,     8,  -1, -1, 1, 3,     7,     15,    1'b0});
    vecs.push_back('{"req_abort",  16'd4,     0,  -1, -1, 1, 5,     9,     17,    1'b0});
    vecs.push_back('{"meas37",     16'd37,    -1, -1, -1, 1, 38,    42,    50,    1'b0});
    vecs.push_back('{"clamp",      16'd65535, -1, -1, -1, 1, 60001, 60005, 60013, 1'b1});
    vecs.push_back('{"unclamp",    16'd3,     -1, -1, -1, 1, 4,     8,     16,    1'b0});

    reset    = 1'b0;
    req      = 1'b0;
    abort    = 1'b0;
    interval = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", 0, {start, stop, busy, done, clamped}, 5'b00000);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // abort alone in IDLE must not start anything
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
    chk("abort_idle", 0, {start, stop, busy, done, clamped}, 5'b00000);

    foreach (vecs[i]) run_vec(vecs[i]);

    // asynchronous reset in the middle of BOTH_HI
    req      = 1'b1;
    interval = 16'd10;
    tick();
    req = 1'b0;
    repeat (11) tick();
    chk("pre_reset_both", 12, {start, stop, busy, done, clamped}, 5'b11100);
    #2;
    reset = 1'b0;
    #1;
    chk("async_reset", 12, {start, stop, busy, done, clamped}, 5'b00000);
    @(negedge clk);
    reset = 1'b1;
    tick();
    run_vec('{"after_reset", 16'd2, -1, -1, -1, 1, 3, 7, 15, 1'b0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
